// File: rtl/branch_target_buffer_pkg.sv
// Shared types and helpers for the fetch-stage branch target buffer.
// Supplies BranchOutcome and a default `ADDR_WIDTH for builds that do not
// already provide them.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package branch_target_buffer_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    localparam logic [1:0] BTB_CTR_WEAK_TAKEN   = 2'b10;
    localparam logic [1:0] BTB_CTR_STRONG_TAKEN = 2'b11;

    // Widest tag any legal INDEX_BITS can produce; narrower tags are zero-extended.
    localparam int unsigned BTB_TAG_FIELD_BITS = `ADDR_WIDTH - 2;

    typedef struct packed {
        logic                          valid;
        logic [BTB_TAG_FIELD_BITS-1:0] tag;
        logic [`ADDR_WIDTH-1:0]        target;
        logic [1:0]                    counter;
    } btb_entry_t;

    // Two-bit saturating hysteresis step.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input BranchOutcome outcome);
        if (outcome == TAKEN) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_target_buffer_stats.sv
// Free-running lookup and hit counters for the branch target buffer.
// Wrap modulo 2^32; cleared only by reset, never by a BTB flush.

module btb_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_valid,
    input  logic        hit,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits
);

    logic [31:0] lookups_q;
    logic [31:0] hits_q;

    // Count presented lookups and resulting hits each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            if (lookup_valid) begin
                lookups_q <= lookups_q + 32'd1;
            end
            if (hit) begin
                hits_q <= hits_q + 32'd1;
            end
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_hits    = hits_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer for the fetch stage.
// Combinational lookup, registered update from execute, flush clears valids.
// Optional statistics counters are enabled with `define BTB_STATS_EN.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = `ADDR_WIDTH - INDEX_BITS - 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_lookup_valid,
    input  logic [`ADDR_WIDTH-1:0] i_lookup_pc,
    output logic                   o_hit,
    output logic                   o_predict_taken,
    output logic [`ADDR_WIDTH-1:0] o_next_pc,
    input  logic                   i_update_valid,
    input  logic [`ADDR_WIDTH-1:0] i_update_pc,
    input  logic [`ADDR_WIDTH-1:0] i_update_target,
    input  BranchOutcome           i_update_outcome,
    input  logic                   i_update_is_jump,
    input  logic                   i_flush,
    output logic [31:0]            o_stat_lookups,
    output logic [31:0]            o_stat_hits
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    // Valid bits and counters are reset; tags and targets are plain storage.
    logic [ENTRIES-1:0]     valid_q;
    logic [1:0]             ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0]    tag_q    [ENTRIES];
    logic [`ADDR_WIDTH-1:0] target_q [ENTRIES];

    logic [INDEX_BITS-1:0]         lk_idx;
    logic [TAG_BITS-1:0]           lk_tag;
    logic [BTB_TAG_FIELD_BITS-1:0] lk_tag_ext;
    btb_entry_t                    lk_entry;
    logic                          lk_hit;

    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic                  up_alloc;
    logic                  up_write;

    logic unused_pc_low;

    assign lk_idx = i_lookup_pc[INDEX_BITS+1:2];
    assign lk_tag = i_lookup_pc[`ADDR_WIDTH-1:INDEX_BITS+2];
    assign up_idx = i_update_pc[INDEX_BITS+1:2];
    assign up_tag = i_update_pc[`ADDR_WIDTH-1:INDEX_BITS+2];

    // Byte offset within the word plays no part in mapping.
    assign unused_pc_low = ^{i_lookup_pc[1:0], i_update_pc[1:0]};

    // Assemble the indexed entry for the lookup port.
    always_comb begin
        lk_entry                      = '0;
        lk_entry.valid                = valid_q[lk_idx];
        lk_entry.tag[TAG_BITS-1:0]    = tag_q[lk_idx];
        lk_entry.target               = target_q[lk_idx];
        lk_entry.counter              = ctr_q[lk_idx];
        lk_tag_ext                    = '0;
        lk_tag_ext[TAG_BITS-1:0]      = lk_tag;
    end

    // Zero-latency prediction; a miss or idle fetch falls through to pc+4.
    always_comb begin
        lk_hit          = i_lookup_valid && lk_entry.valid && (lk_entry.tag == lk_tag_ext);
        o_hit           = lk_hit;
        o_predict_taken = lk_hit && lk_entry.counter[1];
        o_next_pc       = o_predict_taken ? lk_entry.target : i_lookup_pc + `ADDR_WIDTH'(4);
    end

    // Classify the incoming update against the currently stored entry.
    always_comb begin
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_alloc = !up_hit && ((i_update_outcome == TAKEN) || i_update_is_jump);
        up_write = i_update_valid && !i_flush && (up_hit || up_alloc);
    end

    // Valid bits and hysteresis counters; flush wins over a same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BTB_CTR_WEAK_TAKEN;
            end
        end else if (i_flush) begin
            valid_q <= '0;
        end else if (i_update_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= i_update_is_jump ? BTB_CTR_STRONG_TAKEN
                                                  : sat_update(ctr_q[up_idx], i_update_outcome);
            end else if (up_alloc) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= i_update_is_jump ? BTB_CTR_STRONG_TAKEN : BTB_CTR_WEAK_TAKEN;
            end
        end
    end

    // Tag and target storage; contents behind a cleared valid bit are ignored.
    always_ff @(posedge clk) begin
        if (up_write) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= i_update_target;
        end
    end

`ifdef BTB_STATS_EN
    btb_stats u_stats (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (i_lookup_valid),
        .hit          (lk_hit),
        .stat_lookups (o_stat_lookups),
        .stat_hits    (o_stat_hits)
    );
`else
    assign o_stat_lookups = '0;
    assign o_stat_hits    = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_target_buffer;
    import branch_target_buffer_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   i_lookup_valid;
    logic [`ADDR_WIDTH-1:0] i_lookup_pc;
    logic                   o_hit;
    logic                   o_predict_taken;
    logic [`ADDR_WIDTH-1:0] o_next_pc;
    logic                   i_update_valid;
    logic [`ADDR_WIDTH-1:0] i_update_pc;
    logic [`ADDR_WIDTH-1:0] i_update_target;
    BranchOutcome           i_update_outcome;
    logic                   i_update_is_jump;
    logic                   i_flush;
    logic [31:0]            o_stat_lookups;
    logic [31:0]            o_stat_hits;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_buffer #(.INDEX_BITS(6)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_lookup_valid   (i_lookup_valid),
        .i_lookup_pc      (i_lookup_pc),
        .o_hit            (o_hit),
        .o_predict_taken  (o_predict_taken),
        .o_next_pc        (o_next_pc),
        .i_update_valid   (i_update_valid),
        .i_update_pc      (i_update_pc),
        .i_update_target  (i_update_target),
        .i_update_outcome (i_update_outcome),
        .i_update_is_jump (i_update_is_jump),
        .i_flush          (i_flush),
        .o_stat_lookups   (o_stat_lookups),
        .o_stat_hits      (o_stat_hits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tgt,
                          input BranchOutcome outcome, input logic jump);
        i_update_valid   = 1'b1;
        i_update_pc      = pc;
        i_update_target  = tgt;
        i_update_outcome = outcome;
        i_update_is_jump = jump;
        tick();
        i_update_valid   = 1'b0;
        i_update_is_jump = 1'b0;
    endtask

    // Lookup sampled mid-low-phase so it never straddles a clock edge.
    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_hit, input logic exp_taken, input logic [31:0] exp_next);
        @(negedge clk);
        i_lookup_valid = 1'b1;
        i_lookup_pc    = pc;
        #1;
        check({tag, ".hit"},   {31'd0, o_hit},           {31'd0, exp_hit});
        check({tag, ".taken"}, {31'd0, o_predict_taken}, {31'd0, exp_taken});
        check({tag, ".next"},  o_next_pc,                exp_next);
        i_lookup_valid = 1'b0;
    endtask

    task automatic check_stats(input string tag, input logic [31:0] exp_lk, input logic [31:0] exp_hits);
`ifdef BTB_STATS_EN
        check({tag, ".lookups"}, o_stat_lookups, exp_lk);
        check({tag, ".hits"},    o_stat_hits,    exp_hits);
`else
        check({tag, ".lookups"}, o_stat_lookups, 32'd0 & exp_lk);
        check({tag, ".hits"},    o_stat_hits,    32'd0 & exp_hits);
`endif
    endtask

    initial begin
        rst_n            = 1'b0;
        i_lookup_valid   = 1'b0;
        i_lookup_pc      = 32'h40;
        i_update_valid   = 1'b0;
        i_update_pc      = '0;
        i_update_target  = '0;
        i_update_outcome = NOT_TAKEN;
        i_update_is_jump = 1'b0;
        i_flush          = 1'b0;

        #2;
        check("rst.hit",  {31'd0, o_hit}, 32'd0);
        check("rst.next", o_next_pc, 32'h44);
        check_stats("rst", 32'd0, 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        // One lookup cycle crossing a rising edge.
        @(negedge clk);
        i_lookup_valid = 1'b1;
        i_lookup_pc    = 32'h40;
        #1;
        check("first.hit",  {31'd0, o_hit}, 32'd0);
        check("first.next", o_next_pc, 32'h44);
        tick();
        i_lookup_valid = 1'b0;
        check_stats("first", 32'd1, 32'd0);

        // Allocation and hysteresis walk on 0x40.
        update(32'h40, 32'h100, TAKEN, 1'b0);
        lookup("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        update(32'h40, 32'h100, NOT_TAKEN, 1'b0);
        lookup("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
        update(32'h40, 32'h100, NOT_TAKEN, 1'b0);
        lookup("nt2", 32'h40, 1'b1, 1'b0, 32'h44);
        update(32'h40, 32'h100, TAKEN, 1'b0);
        lookup("t_from0", 32'h40, 1'b1, 1'b0, 32'h44);
        update(32'h40, 32'h200, NOT_TAKEN, 1'b1);
        lookup("jump", 32'h40, 1'b1, 1'b1, 32'h200);
        update(32'h40, 32'h200, NOT_TAKEN, 1'b0);
        lookup("jump_nt", 32'h40, 1'b1, 1'b1, 32'h200);

        // Aliasing entries at index 16.
        update(32'h140, 32'h300, TAKEN, 1'b0);
        lookup("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
        lookup("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);
        update(32'h240, 32'h999, NOT_TAKEN, 1'b0);
        lookup("nt_miss_keep", 32'h140, 1'b1, 1'b1, 32'h300);
        lookup("nt_miss_none", 32'h240, 1'b0, 1'b0, 32'h244);

        // Same-cycle update and lookup sees old contents.
        @(negedge clk);
        i_update_valid   = 1'b1;
        i_update_pc      = 32'h80;
        i_update_target  = 32'h400;
        i_update_outcome = TAKEN;
        i_lookup_valid   = 1'b1;
        i_lookup_pc      = 32'h80;
        #1;
        check("same.hit",  {31'd0, o_hit}, 32'd0);
        check("same.next", o_next_pc, 32'h84);
        tick();
        i_update_valid = 1'b0;
        i_lookup_valid = 1'b0;
        lookup("same_after", 32'h80, 1'b1, 1'b1, 32'h400);
        lookup("low_bits", 32'h83, 1'b1, 1'b1, 32'h400);

        // Idle fetch on a trained PC.
        @(negedge clk);
        i_lookup_valid = 1'b0;
        i_lookup_pc    = 32'h80;
        #1;
        check("idle.hit",   {31'd0, o_hit}, 32'd0);
        check("idle.taken", {31'd0, o_predict_taken}, 32'd0);
        check("idle.next",  o_next_pc, 32'h84);

        // Flush beats a same-cycle update.
        i_flush = 1'b1;
        update(32'h1C0, 32'h500, TAKEN, 1'b0);
        i_flush = 1'b0;
        lookup("flush_80",  32'h80,  1'b0, 1'b0, 32'h84);
        lookup("flush_140", 32'h140, 1'b0, 1'b0, 32'h144);
        lookup("flush_1c0", 32'h1C0, 1'b0, 1'b0, 32'h1C4);

        // Jump miss allocates strongly taken.
        update(32'h500, 32'h600, NOT_TAKEN, 1'b1);
        lookup("jalloc", 32'h500, 1'b1, 1'b1, 32'h600);
        update(32'h500, 32'h600, NOT_TAKEN, 1'b0);
        lookup("jalloc_nt1", 32'h500, 1'b1, 1'b1, 32'h600);
        update(32'h500, 32'h600, NOT_TAKEN, 1'b0);
        lookup("jalloc_nt2", 32'h500, 1'b1, 1'b0, 32'h504);

        // Asynchronous reset mid-cycle with an update in flight.
        update(32'h80, 32'h400, TAKEN, 1'b0);
        lookup("pre_rst", 32'h80, 1'b1, 1'b1, 32'h400);
        @(negedge clk);
        i_lookup_valid   = 1'b1;
        i_lookup_pc      = 32'h80;
        i_update_valid   = 1'b1;
        i_update_pc      = 32'h80;
        i_update_target  = 32'h700;
        i_update_outcome = TAKEN;
        #1;
        rst_n = 1'b0;
        #1;
        check("async.hit",  {31'd0, o_hit}, 32'd0);
        check("async.next", o_next_pc, 32'h84);
        check_stats("async", 32'd0, 32'd0);
        tick();
        i_update_valid = 1'b0;
        i_lookup_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lookup("post_rst", 32'h80, 1'b0, 1'b0, 32'h84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
